pe_cluster_ctrl: RTL
====================

# pe_cluster_ctrl

Sequencer for the 4x4 weight/activation systolic cluster (`pe_4x4_cluster`).
- Accepts one K-deep tile job through a start/ready handshake and latches the full operand tiles.
- Clears the cluster, then streams row-skewed activations and column-skewed weights into the cluster's 64-bit edge buses.
- Holds the cluster enabled through a fixed drain window, then captures all 16 PE sums and pulses `done`.
- Sits between the tile buffer/host logic and the PE array; one job in flight at a time.

## Interface
Parameters:
- `K`, 4: reduction depth, number of operand elements per lane; legal range 1..16.
- `DRAIN_CYCLES`, 8: cycles the cluster stays enabled after the last operand enters; legal range ≥ 1.

Ports:
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: job request; accepted on an edge where `start && ready`.
- `ready`  out  1: high only in IDLE.
- `act_tile`  in  64*K: A[i][k] at bits [(i*K+k)*16 +: 16], i = row 0..3; sampled on accept only.
- `wgt_tile`  in  64*K: W[k][j] at bits [(k*4+j)*16 +: 16], j = column 0..3; sampled on accept only.
- `pe_act`  out  64: activation lane i at [i*16 +: 16], driven to the cluster `activations` input.
- `pe_wgt`  out  64: weight lane j at [j*16 +: 16], driven to the cluster `weights` input.
- `pe_en`  out  1: cluster enable.
- `pe_rst_n`  out  1: active-low cluster clear.
- `pe_results`  in  576: PE(r,c) sum at [(r*4+c)*36 +: 36].
- `res`  out  576: captured sums, same packing as `pe_results`.
- `busy`  out  1: high from the cycle after accept through the DONE cycle.
- `done`  out  1: one-cycle pulse, `res` valid from this cycle on.

## Operation
- FSM states: IDLE, CLEAR, FEED, DRAIN, DONE. All outputs are registered.
- IDLE: `ready`=1. On accept, latch both tiles and go to CLEAR.
- CLEAR (1 cycle): `pe_rst_n`=0, `pe_en`=0, lanes 0. Go to FEED with t=0.
- FEED (K+3 cycles, t = 0..K+2): `pe_en`=1.
  - `pe_act` lane i = A[i][t-i] when 0 ≤ t-i < K, else 0.
  - `pe_wgt` lane j = W[t-j][j] when 0 ≤ t-j < K, else 0.
  - After t=K+2, go to DRAIN.
- DRAIN (`DRAIN_CYCLES` cycles): `pe_en`=1, lanes 0. On the edge ending the last drain cycle, `res` ← `pe_results`; go to DONE.
- DONE (1 cycle): `done`=1. Then return to IDLE.
- Arithmetic: only the feed index t and the drain counter; no data arithmetic. Counter width is clog2(K+3) or clog2(DRAIN_CYCLES), whichever is larger. Operands pass through unmodified.
- `start` outside IDLE is ignored and not queued. Tile inputs may change freely after accept.
- `res` holds its value until the next capture.

## Timing
- Reset values: state IDLE, `ready`=1, `busy`=0, `done`=0, `pe_en`=0, `pe_rst_n`=0, `pe_act`=`pe_wgt`=0, `res`=0, counters 0.
- First IDLE cycle after reset: `pe_rst_n`=1.
- Let accept edge = E0:
  - CLEAR occupies cycle 1.
  - FEED occupies cycles 2..K+4.
  - DRAIN occupies cycles K+5..K+4+DRAIN_CYCLES.
  - `done` is high in cycle K+5+DRAIN_CYCLES (17 with defaults).
  - `ready` returns to 1 in the cycle after `done`.
- Back-to-back: a `start` held high is accepted on the first IDLE edge. Minimum job period is K+6+DRAIN_CYCLES cycles.
- `rst` asserted in any state, including mid-FEED or on the DONE cycle: the next cycle shows all reset values, and `res` is cleared. No capture or `done` occurs for the aborted job.
- `rst` and `start` high on the same edge: reset wins and the job is not accepted.

## Configuration
- `PE_CTRL_PERF_EN` defined:
  - Adds output `tile_cnt` (16 bits).
  - It increments on every `done` pulse and wraps 0xFFFF → 0x0000.
  - Cleared by `rst`.
- `PE_CTRL_PERF_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset check: hold `rst` 3 cycles, then release. Required: every output at its reset value during reset, `pe_rst_n`=1 and `ready`=1 in the first cycle after release.
- Single job, defaults: A[i][k]=16*i+k+1, W[k][j]=16*k+j+1, start pulsed one cycle.
  - Required: `busy` rises in cycle 1 and `pe_rst_n`=0 in cycle 1.
  - Required: in cycle 2 only lanes 0 are nonzero (`pe_act`[15:0]=0x0001, `pe_wgt`[15:0]=0x0001).
  - Required: in cycle 5, `pe_act` lane 3 = 0x0031 and `pe_wgt` lane 3 = 0x0004.
  - Required: `done` in cycle 17, `res` = `pe_results` sampled at that edge.
- Skew boundary, K=1 and DRAIN_CYCLES=1: FEED lasts 4 cycles, each lane nonzero in exactly one cycle, `done` in cycle 7.
- Busy rejection: `start` held high continuously. Required: a second accept only after DONE, with `done` pulses 18 cycles apart. Tile changes during a job do not alter the streamed values.
- Mid-run reset: assert `rst` in FEED cycle 3. Required: the next cycle shows `pe_en`=0, `res`=0, IDLE; no `done` pulse; a subsequent job completes normally.
- With `PE_CTRL_PERF_EN`: run 3 jobs, `tile_cnt` = 3. Force the counter to 0xFFFF and run one job: `tile_cnt` = 0x0000.

Source files
------------

// File: rtl/pe_cluster_ctrl.sv
// pe_cluster_ctrl: sequencer for the 4x4 weight/activation systolic cluster.
// Accepts one K-deep tile job, clears the cluster, streams row-skewed
// activations and column-skewed weights, drains, then captures all 16 sums.
// Optional build macro PE_CTRL_PERF_EN adds a 16-bit completed-tile counter
// output (tile_cnt).
module pe_cluster_ctrl #(
  parameter int K            = 4,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            ready,
  input  logic [64*K-1:0] act_tile,
  input  logic [64*K-1:0] wgt_tile,
  output logic [63:0]     pe_act,
  output logic [63:0]     pe_wgt,
  output logic            pe_en,
  output logic            pe_rst_n,
  input  logic [575:0]    pe_results,
  output logic [575:0]    res,
  output logic            busy,
  output logic            done
`ifdef PE_CTRL_PERF_EN
  ,
  output logic [15:0]     tile_cnt
`endif
);

  localparam int FEED_W  = $clog2(K + 3);
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int CW      = (FEED_W > DRAIN_W) ? FEED_W : DRAIN_W;

  localparam logic [CW-1:0] FEED_LAST  = CW'(K + 2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [64*K-1:0] act_q;
  logic [64*K-1:0] wgt_q;

  logic            ready_d;
  logic            busy_d;
  logic            done_d;
  logic            pe_en_d;
  logic            pe_rst_n_d;
  logic [63:0]     pe_act_d;
  logic [63:0]     pe_wgt_d;

  // State and shared feed/drain counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state and counter sequencing through clear, feed, drain and done
  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          next_state = S_CLEAR;
          cnt_next   = '0;
        end
      end
      S_CLEAR: begin
        next_state = S_FEED;
        cnt_next   = '0;
      end
      S_FEED: begin
        if (cnt == FEED_LAST) begin
          next_state = S_DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt == DRAIN_LAST) begin
          next_state = S_DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      S_DONE: begin
        next_state = S_IDLE;
        cnt_next   = '0;
      end
      default: begin
        next_state = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Output values for the upcoming state, including the skewed lane selection
  always_comb begin
    ready_d    = (next_state == S_IDLE);
    busy_d     = (next_state != S_IDLE);
    done_d     = (next_state == S_DONE);
    pe_en_d    = (next_state == S_FEED) || (next_state == S_DRAIN);
    pe_rst_n_d = (next_state != S_CLEAR);
    pe_act_d   = '0;
    pe_wgt_d   = '0;
    if (next_state == S_FEED) begin
      for (int i = 0; i < 4; i++) begin
        if ((int'(cnt_next) >= i) && (int'(cnt_next) < i + K)) begin
          pe_act_d[i*16 +: 16] = act_q[(i*K + int'(cnt_next) - i)*16 +: 16];
          pe_wgt_d[i*16 +: 16] = wgt_q[((int'(cnt_next) - i)*4 + i)*16 +: 16];
        end
      end
    end
  end

  // Registered outputs and result capture on the last drain edge
  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      pe_en    <= 1'b0;
      pe_rst_n <= 1'b0;
      pe_act   <= '0;
      pe_wgt   <= '0;
      res      <= '0;
    end else begin
      ready    <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
      pe_en    <= pe_en_d;
      pe_rst_n <= pe_rst_n_d;
      pe_act   <= pe_act_d;
      pe_wgt   <= pe_wgt_d;
      if ((state == S_DRAIN) && (cnt == DRAIN_LAST)) begin
        res <= pe_results;
      end
    end
  end

  // Operand tiles are latched on accept so the host may change them afterwards
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= '0;
      wgt_q <= '0;
    end else if ((state == S_IDLE) && start) begin
      act_q <= act_tile;
      wgt_q <= wgt_tile;
    end
  end

`ifdef PE_CTRL_PERF_EN
  // Completed-tile counter, stepping together with the done pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      tile_cnt <= '0;
    end else if (next_state == S_DONE) begin
      tile_cnt <= tile_cnt + 16'd1;
    end
  end
`endif

endmodule
